// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// master: controlling FSM side; slave: the subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, busy, done
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = (a - b) mod 2^WIDTH, LSB first, one bit per clk.
// Optional build macro SERIAL_SUB_SAT_EN: when defined, a negative result
// (final borrow = 1) is clamped to diff = 0; borrow still reports 1.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one bit processed per edge, busy = 1
// DONE  | diff/borrow valid, done = 1 for one cycle
module serial_sub #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_sub_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             bin;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic             d;
  logic             bout;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_final;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ bin;
    bout     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);
    res_next = {d, res[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
    diff_final = bout ? '0 : res_next;
`else
    diff_final = res_next;
`endif
  end

  // Sequencer; the result register is internal so diff only changes on the final edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      bin      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res    <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bout;
          res  <= res_next;
          if (cnt == LAST_BIT) begin
            diff_q   <= diff_final;
            borrow_q <= bout;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
